// File: rtl/carfield_l2_dual_arb_pkg.sv
// Shared types, default address map and decode helper for the dual-ported L2 arbiter.
package carfield_l2_dual_arb_pkg;

   typedef enum logic [1:0] {PORT0, PORT1, PORT_ERR} port_sel_e;

   localparam logic [63:0] DefL2Base     = 64'h0000_0000_7800_0000;
   localparam int unsigned DefL2PortSize = 32'h0002_0000;

   // Port 0 covers [base, base+size), port 1 the following size bytes.
   function automatic port_sel_e decode_port(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input logic [63:0] size);
      if (addr >= base && addr < base + size)
         return PORT0;
      if (addr >= base + size && addr < base + (size << 1))
         return PORT1;
      return PORT_ERR;
   endfunction

endpackage

// File: rtl/carfield_l2_dual_arb_if.sv
// Requester-side and L2-side signal bundle of the dual-port arbiter.
interface carfield_l2_dual_arb_if
   import carfield_l2_dual_arb_pkg::*;
#(
   parameter int unsigned NumReq     = 4,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned L2PortSize = DefL2PortSize
) ();
   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned OffWidth = $clog2(L2PortSize);

   logic [NumReq-1:0]                req_i;
   logic [NumReq-1:0][AddrWidth-1:0] addr_i;
   logic [NumReq-1:0]                we_i;
   logic [NumReq-1:0][DataWidth-1:0] wdata_i;
   logic [NumReq-1:0][BeWidth-1:0]   be_i;
   logic [NumReq-1:0]                gnt_o;
   logic [NumReq-1:0]                rvalid_o;
   logic [NumReq-1:0][DataWidth-1:0] rdata_o;
   logic [NumReq-1:0]                err_o;

   logic [1:0]                l2_req_o;
   logic [1:0][OffWidth-1:0]  l2_addr_o;
   logic [1:0]                l2_we_o;
   logic [1:0][DataWidth-1:0] l2_wdata_o;
   logic [1:0][BeWidth-1:0]   l2_be_o;
   logic [1:0]                l2_gnt_i;
   logic [1:0]                l2_rvalid_i;
   logic [1:0][DataWidth-1:0] l2_rdata_i;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o, l2_req_o, l2_addr_o, l2_we_o, l2_wdata_o, l2_be_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i, l2_gnt_i, l2_rvalid_i, l2_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, l2_req_o, l2_addr_o, l2_we_o, l2_wdata_o, l2_be_o
   );

endinterface

// File: rtl/carfield_l2_id_fifo.sv
// In-order ID FIFO remembering which requester owns each outstanding L2 transaction.
module carfield_l2_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Depth-1:0][Width-1:0] mem_q;
   logic [PtrW-1:0]             wr_ptr_q;
   logic [PtrW-1:0]             rd_ptr_q;
   logic [CntW-1:0]             cnt_q;
   logic                        do_push;
   logic                        do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push != do_pop)
            cnt_q <= do_push ? cnt_q + CntW'(1) : cnt_q - CntW'(1);
      end
   end

endmodule

// File: rtl/carfield_l2_dual_arb.sv
// Steers requesters onto the two L2 ports with per-port round-robin, routes in-order
// responses back via ID FIFOs and answers out-of-range accesses locally with an error.
module carfield_l2_dual_arb
   import carfield_l2_dual_arb_pkg::*;
#(
   parameter int unsigned NumReq     = 4,
   parameter int unsigned AddrWidth  = 48,
   parameter int unsigned DataWidth  = 64,
   parameter logic [63:0] L2Base     = DefL2Base,
   parameter int unsigned L2PortSize = DefL2PortSize,
   parameter int unsigned MaxOut     = 4
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   carfield_l2_dual_arb_if.slave bus
);
   localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned CntW = $clog2(2 * MaxOut + 1);
   localparam int unsigned OffW = $clog2(L2PortSize);

   port_sel_e                   tgt [NumReq];
   logic [1:0][IdW-1:0]         rr_ptr_q, rr_ptr_d, win_id, fifo_head;
   logic [1:0]                  win_vld, hs, pop, fifo_full, fifo_empty;
   logic [NumReq-1:0][CntW-1:0] out_cnt_q, out_cnt_d;
   logic [NumReq-1:0]           cur_port_q, cur_port_d, err_pend_q, err_gnt;
   int                          idx;

   always_comb begin
      for (int r = 0; r < NumReq; r++)
         tgt[r] = decode_port(64'(bus.addr_i[r]), L2Base, 64'(L2PortSize));
   end

   // A requester with traffic in flight on one port may not start on the other.
   always_comb begin
      win_vld = '0;
      win_id  = '0;
      idx     = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < int'(NumReq); i++) begin
            idx = (int'(rr_ptr_q[p]) + i) % int'(NumReq);
            if (!win_vld[p] && bus.req_i[idx] && tgt[idx] == ((p == 0) ? PORT0 : PORT1) &&
                (out_cnt_q[idx] == '0 || cur_port_q[idx] == 1'(p))) begin
               win_vld[p] = 1'b1;
               win_id[p]  = IdW'(idx);
            end
         end
      end
   end

   always_comb begin
      bus.l2_req_o   = '0;
      bus.l2_addr_o  = '0;
      bus.l2_we_o    = '0;
      bus.l2_wdata_o = '0;
      bus.l2_be_o    = '0;
      hs             = '0;
      pop            = '0;
      rr_ptr_d       = rr_ptr_q;
      for (int p = 0; p < 2; p++) begin
         bus.l2_req_o[p] = win_vld[p] & ~fifo_full[p];
         hs[p]           = bus.l2_req_o[p] & bus.l2_gnt_i[p];
         pop[p]          = bus.l2_rvalid_i[p] & ~fifo_empty[p];
         if (bus.l2_req_o[p]) begin
            bus.l2_addr_o[p]  = OffW'(64'(bus.addr_i[win_id[p]]) -
                                      (L2Base + ((p == 1) ? 64'(L2PortSize) : 64'd0)));
            bus.l2_we_o[p]    = bus.we_i[win_id[p]];
            bus.l2_wdata_o[p] = bus.wdata_i[win_id[p]];
            bus.l2_be_o[p]    = bus.be_i[win_id[p]];
         end
         if (hs[p])
            rr_ptr_d[p] = IdW'((int'(win_id[p]) + 1) % int'(NumReq));
      end
   end

   // Error grants only when idle, so the local error response never collides with an L2 one.
   always_comb begin
      bus.gnt_o    = '0;
      bus.rvalid_o = err_pend_q;
      bus.err_o    = err_pend_q;
      bus.rdata_o  = '0;
      err_gnt      = '0;
      out_cnt_d    = out_cnt_q;
      cur_port_d   = cur_port_q;
      for (int r = 0; r < NumReq; r++) begin
         err_gnt[r]   = bus.req_i[r] && tgt[r] == PORT_ERR && out_cnt_q[r] == '0 && !err_pend_q[r];
         bus.gnt_o[r] = err_gnt[r];
         for (int p = 0; p < 2; p++) begin
            if (hs[p] && win_id[p] == IdW'(r)) begin
               bus.gnt_o[r]  = 1'b1;
               out_cnt_d[r]  = out_cnt_d[r] + CntW'(1);
               cur_port_d[r] = 1'(p);
            end
            if (pop[p] && fifo_head[p] == IdW'(r)) begin
               bus.rvalid_o[r] = 1'b1;
               bus.rdata_o[r]  = bus.l2_rdata_i[p];
               out_cnt_d[r]    = out_cnt_d[r] - CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         out_cnt_q  <= '0;
         cur_port_q <= '0;
         err_pend_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         out_cnt_q  <= out_cnt_d;
         cur_port_q <= cur_port_d;
         err_pend_q <= err_gnt;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      carfield_l2_id_fifo #(
         .Depth (MaxOut),
         .Width (IdW)
      ) i_id_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (hs[p]),
         .data_i  (win_id[p]),
         .pop_i   (pop[p]),
         .full_o  (fifo_full[p]),
         .empty_o (fifo_empty[p]),
         .head_o  (fifo_head[p])
      );

      rvalid_needs_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(bus.l2_rvalid_i[p] && fifo_empty[p]));
   end

endmodule
